// File: rtl/fft_pkg.sv
// Shared constants for the 8-point Q8.8 FFT datapath.
// Used by the input framer and by the FFT core itself.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int FFT_N  = 8;
    localparam int IDX_W  = $clog2(FFT_N);

    // Q8.8 unity
    localparam logic [DATA_W-1:0] ONE = 16'h0100;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

endpackage

// File: rtl/fft_frame_bank.sv
// One 8-entry sample bank of the double-buffered framer.
// Single write port, all entries visible in parallel on a flat bus.
module fft_frame_bank #(
    parameter int W = fft_pkg::DATA_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            we_i,
    input  logic [fft_pkg::IDX_W-1:0]       idx_i,
    input  logic [W-1:0]                    din_i,
    output logic [fft_pkg::FFT_N*W-1:0]     dout_o
);

    import fft_pkg::*;

    logic [W-1:0] mem_q [FFT_N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= din_i;
        end
    end

    always_comb begin
        dout_o = '0;
        for (int i = 0; i < FFT_N; i++) begin
            dout_o[i*W +: W] = mem_q[i];
        end
    end

endmodule

// File: rtl/fft8_input_framer.sv
// Serial-to-parallel framer feeding the combinational 8-point FFT.
// Two banks ping-pong: one fills from the stream while the other is consumed.
module fft8_input_framer #(
    parameter int DATA_W   = fft_pkg::DATA_W,
    parameter bit CHK_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic              f_valid,
    input  logic              f_ready,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    import fft_pkg::*;

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [FFT_N*DATA_W-1:0] dout [2];
    logic [FFT_N*DATA_W-1:0] sel;

    logic s_fire, f_fire, at_last, drop, miss;

    assign s_ready = !full_q[wr_bank_q];
    assign f_valid = full_q[rd_bank_q];
    assign s_fire  = s_valid && s_ready;
    assign f_fire  = f_valid && f_ready;
    assign at_last = (wr_idx_q == LAST_IDX);
    assign drop    = CHK_LAST && s_last && !at_last;
    assign miss    = CHK_LAST && !s_last && at_last;

    // Fill and drain never hit the same bank: a full write bank stalls input.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        if (f_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            cnt_d             = cnt_q + 8'd1;
        end
        if (s_fire) begin
            err_d = drop || miss;
            unique case (1'b1)
                at_last: begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                    wr_idx_d          = '0;
                end
                drop:    wr_idx_d = '0;
                default: wr_idx_d = wr_idx_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .W (DATA_W)
        ) u_bank (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .we_i   (s_fire && (wr_bank_q == b[0])),
            .idx_i  (wr_idx_q),
            .din_i  (s_data),
            .dout_o (dout[b])
        );
    end

    assign sel = dout[rd_bank_q];

    assign x0 = sel[0*DATA_W +: DATA_W];
    assign x1 = sel[1*DATA_W +: DATA_W];
    assign x2 = sel[2*DATA_W +: DATA_W];
    assign x3 = sel[3*DATA_W +: DATA_W];
    assign x4 = sel[4*DATA_W +: DATA_W];
    assign x5 = sel[5*DATA_W +: DATA_W];
    assign x6 = sel[6*DATA_W +: DATA_W];
    assign x7 = sel[7*DATA_W +: DATA_W];

    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft8_input_framer.sv
// Directed bench for fft8_input_framer (CHK_LAST=1 and CHK_LAST=0 copies).
module tb_fft8_input_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, f_ready = 1'b0;
    logic        s_ready, f_valid, frame_err;
    logic [7:0]  frame_cnt;
    logic [15:0] x0, x1, x2, x3, x4, x5, x6, x7;

    logic [15:0] s_data_b = '0;
    logic        s_valid_b = 1'b0, s_last_b = 1'b0, f_ready_b = 1'b0;
    logic        s_ready_b, f_valid_b, frame_err_b;
    logic [7:0]  frame_cnt_b;
    logic [15:0] y0, y1, y2, y3, y4, y5, y6, y7;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fft8_input_framer #(.DATA_W(16), .CHK_LAST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .f_valid(f_valid), .f_ready(f_ready), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    fft8_input_framer #(.DATA_W(16), .CHK_LAST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b),
        .s_last(s_last_b), .s_ready(s_ready_b),
        .x0(y0), .x1(y1), .x2(y2), .x3(y3), .x4(y4), .x5(y5), .x6(y6), .x7(y7),
        .f_valid(f_valid_b), .f_ready(f_ready_b), .frame_err(frame_err_b),
        .frame_cnt(frame_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        int n = 0;
        s_data = d; s_valid = 1'b1; s_last = l;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("push_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] d, input logic l);
        int n = 0;
        s_data_b = d; s_valid_b = 1'b1; s_last_b = l;
        while (!s_ready_b && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("push_b_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        s_valid_b = 1'b0; s_last_b = 1'b0;
    endtask

    initial begin
        logic [15:0] t1 [8];
        logic [127:0] snap;
        int sent, got, cyc, viol, bad;
        logic s_acc, f_acc, hold;

        t1 = '{16'd256, 16'd384, 16'd512, 16'd640,
               16'd64896, 16'd65024, 16'd65152, 16'd65280};

        // reset state
        #12;
        check("rst_s_ready", s_ready, 1);
        check("rst_f_valid", f_valid, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_err", frame_err, 0);
        check("rst_x0", x0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1) single frame, consumer always ready
        f_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(t1[i], i == 7);
        check("t1_f_valid", f_valid, 1);
        check("t1_err", frame_err, 0);
        check("t1_x0", x0, 16'h0100);
        check("t1_x1", x1, 16'h0180);
        check("t1_x2", x2, 16'h0200);
        check("t1_x3", x3, 16'h0280);
        check("t1_x4", x4, 16'hFD80);
        check("t1_x5", x5, 16'hFE00);
        check("t1_x6", x6, 16'hFE80);
        check("t1_x7", x7, 16'hFF00);
        @(posedge clk); #1;
        check("t1_f_valid_drop", f_valid, 0);
        check("t1_cnt", frame_cnt, 1);

        // 2) back-pressure: both banks fill, then drain in order
        f_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), i == 7);
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i), i == 7);
        check("t2_s_ready_low", s_ready, 0);
        check("t2_f_valid", f_valid, 1);
        check("t2_xA0", x0, 16'h1000);
        repeat (2) begin @(posedge clk); #1; end
        check("t2_s_ready_held", s_ready, 0);
        check("t2_xA0_stable", x0, 16'h1000);
        check("t2_xA7_stable", x7, 16'h1007);
        f_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_cnt_A", frame_cnt, 2);
        check("t2_s_ready_up", s_ready, 1);
        check("t2_fv_B", f_valid, 1);
        check("t2_xB0", x0, 16'h2000);
        check("t2_xB7", x7, 16'h2007);
        @(posedge clk); #1;
        check("t2_cnt_B", frame_cnt, 3);
        check("t2_fv_empty", f_valid, 0);
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i), i == 7);
        check("t2_xC0", x0, 16'h3000);
        check("t2_xC5", x5, 16'h3005);
        @(posedge clk); #1;
        check("t2_cnt_C", frame_cnt, 4);

        // 3) early s_last drops the partial frame
        for (int i = 0; i < 5; i++) push(16'h0E00 + 16'(i), i == 4);
        check("t3_err_pulse", frame_err, 1);
        check("t3_f_valid", f_valid, 0);
        @(posedge clk); #1;
        check("t3_err_clear", frame_err, 0);
        f_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i), i == 7);
        check("t3_f_valid", f_valid, 1);
        check("t3_err", frame_err, 0);
        check("t3_x0", x0, 16'h4000);
        check("t3_x7", x7, 16'h4007);
        f_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_cnt", frame_cnt, 5);

        // 4) missing s_last on 8th sample
        f_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i), 1'b0);
        check("t4_err_pulse", frame_err, 1);
        check("t4_f_valid", f_valid, 1);
        check("t4_x7", x7, 16'h5007);
        f_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_err_clear", frame_err, 0);
        check("t4_cnt", frame_cnt, 6);
        f_ready_b = 1'b0;
        for (int i = 0; i < 8; i++) push_b(16'h5100 + 16'(i), 1'b0);
        check("t4b_err", frame_err_b, 0);
        check("t4b_f_valid", f_valid_b, 1);
        check("t4b_x0", y0, 16'h5100);
        check("t4b_x7", y7, 16'h5107);
        f_ready_b = 1'b1;
        @(posedge clk); #1;
        check("t4b_err_after", frame_err_b, 0);
        check("t4b_cnt", frame_cnt_b, 1);

        // 5) reset mid-frame
        for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i), 1'b0);
        rst_n = 1'b0;
        #2;
        check("t5_rst_f_valid", f_valid, 0);
        check("t5_rst_cnt", frame_cnt, 0);
        check("t5_rst_s_ready", s_ready, 1);
        check("t5_rst_x0", x0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        f_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h7000 + 16'(i), i == 7);
        check("t5_f_valid", f_valid, 1);
        check("t5_x0", x0, 16'h7000);
        check("t5_x3", x3, 16'h7003);
        check("t5_x7", x7, 16'h7007);
        f_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_cnt", frame_cnt, 1);

        // 6) 257 frames with random consumer, counter wrap and hold stability
        rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sent = 0; got = 0; cyc = 0; viol = 0; bad = 0;
        while (got < 257 && cyc < 20000) begin
            s_valid = (sent < 257 * 8);
            s_data  = 16'(sent);
            s_last  = (sent % 8 == 7);
            f_ready = 1'($urandom_range(0, 1));
            #1;
            s_acc = s_valid && s_ready;
            f_acc = f_valid && f_ready;
            hold  = f_valid && !f_ready;
            snap  = {x7, x6, x5, x4, x3, x2, x1, x0};
            if (f_acc && (x0 != 16'(got * 8) || x7 != 16'(got * 8 + 7)))
                bad++;
            @(posedge clk); #1;
            if (s_acc) sent++;
            if (f_acc) got++;
            if (hold && {x7, x6, x5, x4, x3, x2, x1, x0} != snap) viol++;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("t6_frames", got, 257);
        check("t6_cnt_wrap", frame_cnt, 1);
        check("t6_hold_stable", viol, 0);
        check("t6_frame_data", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
